ext_share_arbiter: RTL and testbench

//  Shares one 32-bit immediate extension unit between two requesters, e.g. decode
//  and the branch-target path. Requesters use a valid/ready handshake. A

---
 rtl/ext_share_arbiter.sv | 148 ++++++++++++++
 tb/tb_ext_share_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ext_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ext_share_arbiter
// Description : Two requesters share one 32-bit immediate extension unit.
//               A round-robin or starvation-bounded fixed-priority arbiter
//               grants one request per cycle. The result is held in a
//               one-entry output register with a valid/ready handshake and
//               a requester tag.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_share_arbiter #(
    parameter int MODE         = 0,  // 0 = round-robin, 1 = r0 priority with starvation bound
    parameter int RR_INIT      = 0,  // requester holding round-robin priority after reset
    parameter int STARVE_LIMIT = 4   // r0 grants tolerated while r1 waits (MODE 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid_i,
    input  logic [15:0] r0_imm_i,
    input  logic [1:0]  r0_eop_i,
    output logic        r0_ready_o,
    input  logic        r1_valid_i,
    input  logic [15:0] r1_imm_i,
    input  logic [1:0]  r1_eop_i,
    output logic        r1_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        out_id_o,
    output logic        busy_o
);

    localparam int            CW       = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);
    localparam logic          RR_RESET = (RR_INIT != 0);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_id_q, out_id_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    logic          slot_free;
    logic          pick_r0, pick_r1;
    logic          gnt0, gnt1;
    logic [15:0]   sel_imm;
    logic [1:0]    sel_eop;
    logic [31:0]   ext_result;

    // Arbitration: choose a requester, then gate by output slot availability
    always_comb begin
        pick_r0 = 1'b0;
        pick_r1 = 1'b0;
        if (MODE == 0) begin
            if (r0_valid_i && r1_valid_i) begin
                pick_r1 = rr_ptr_q;
                pick_r0 = !rr_ptr_q;
            end else begin
                pick_r0 = r0_valid_i;
                pick_r1 = r1_valid_i;
            end
        end else begin
            // r1 wins when alone or once r0 has been served LIMIT times in a row
            pick_r1 = r1_valid_i && (!r0_valid_i || (starve_cnt_q == LIMIT));
            pick_r0 = r0_valid_i && !pick_r1;
        end
        slot_free = (state_q == S_EMPTY) || out_ready_i;
        gnt0      = pick_r0 && slot_free;
        gnt1      = pick_r1 && slot_free;
    end

    // Extension unit operating on the granted requester's operands
    always_comb begin
        sel_imm = gnt1 ? r1_imm_i : r0_imm_i;
        sel_eop = gnt1 ? r1_eop_i : r0_eop_i;
        case (sel_eop)
            2'b00:   ext_result = {{16{sel_imm[15]}}, sel_imm};
            2'b01:   ext_result = {16'h0000, sel_imm};
            2'b10:   ext_result = {sel_imm, 16'h0000};
            default: ext_result = {{14{sel_imm[15]}}, sel_imm, 2'b00};
        endcase
    end

    // Next-state logic for the output slot FSM, data register and arbiter state
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            S_EMPTY: if (gnt0 || gnt1) state_d = S_FULL;
            S_FULL:  if (out_ready_i && !(gnt0 || gnt1)) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase

        if (gnt0 || gnt1) begin
            out_data_d = ext_result;
            out_id_d   = gnt1;
        end

        // Priority passes to the requester that was not just served
        if (gnt0) begin
            rr_ptr_d = 1'b1;
        end else if (gnt1) begin
            rr_ptr_d = 1'b0;
        end

        // Count back-to-back r0 wins while r1 is waiting
        if (!r1_valid_i || gnt1) begin
            starve_cnt_d = '0;
        end else if (gnt0 && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_EMPTY;
            out_data_q   <= 32'h0000_0000;
            out_id_q     <= 1'b0;
            rr_ptr_q     <= RR_RESET;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign r0_ready_o  = gnt0;
    assign r1_ready_o  = gnt1;
    assign out_valid_o = (state_q == S_FULL);
    assign busy_o      = (state_q == S_FULL);
    assign out_data_o  = out_data_q;
    assign out_id_o    = out_id_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_share_arbiter
// Description : Self-checking bench for ext_share_arbiter. Instance a is
//               round-robin, instance b is fixed priority with STARVE_LIMIT=4.
//               Inputs change on the falling edge; outputs are sampled 1 ns
//               later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r1_valid, out_ready;
    logic [15:0] r0_imm, r1_imm;
    logic [1:0]  r0_eop, r1_eop;

    logic        a_r0_ready, a_r1_ready, a_out_valid, a_out_id, a_busy;
    logic [31:0] a_out_data;
    logic        b_r0_ready, b_r1_ready, b_out_valid, b_out_id, b_busy;
    logic [31:0] b_out_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ext_share_arbiter #(.MODE(0), .RR_INIT(0), .STARVE_LIMIT(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .r0_valid_i(r0_valid), .r0_imm_i(r0_imm), .r0_eop_i(r0_eop), .r0_ready_o(a_r0_ready),
        .r1_valid_i(r1_valid), .r1_imm_i(r1_imm), .r1_eop_i(r1_eop), .r1_ready_o(a_r1_ready),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
        .out_id_o(a_out_id), .busy_o(a_busy)
    );

    ext_share_arbiter #(.MODE(1), .RR_INIT(0), .STARVE_LIMIT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .r0_valid_i(r0_valid), .r0_imm_i(r0_imm), .r0_eop_i(r0_eop), .r0_ready_o(b_r0_ready),
        .r1_valid_i(r1_valid), .r1_imm_i(r1_imm), .r1_eop_i(r1_eop), .r1_ready_o(b_r1_ready),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
        .out_id_o(b_out_id), .busy_o(b_busy)
    );

    // One cycle of stimulus plus what instance a must show 1 ns after it is applied.
    // Expected out_* reflect the grant made in the previous cycle.
    typedef struct {
        logic        r0v;
        logic [15:0] r0i;
        logic [1:0]  r0e;
        logic        r1v;
        logic [15:0] r1i;
        logic [1:0]  r1e;
        logic        ordy;
        logic        e_r0r;
        logic        e_r1r;
        logic        e_ov;
        logic [31:0] e_data;
        logic        e_id;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_in(input logic v0, input logic [15:0] i0, input logic [1:0] e0,
                          input logic v1, input logic [15:0] i1, input logic [1:0] e1,
                          input logic ordy);
        r0_valid  = v0; r0_imm = i0; r0_eop = e0;
        r1_valid  = v1; r1_imm = i1; r1_eop = e1;
        out_ready = ordy;
    endtask

    initial begin
        logic g1_exp [6];

        // ext ops from r0
        vecs[0]  = '{1'b1, 16'h8001, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h8001, 2'd1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_8001, 1'b0};
        vecs[2]  = '{1'b1, 16'h1234, 2'd2, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_8001, 1'b0};
        vecs[3]  = '{1'b1, 16'hFFFF, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_0000, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0};
        // drained; r1 alone (rr_ptr=1 here) brings rr_ptr to 0
        vecs[5]  = '{1'b0, 16'h0000, 2'd0, 1'b1, 16'h0004, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        // both valid for 4 cycles: r0, r1, r0, r1
        vecs[6]  = '{1'b1, 16'h0010, 2'd1, 1'b1, 16'h0020, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b1};
        vecs[7]  = '{1'b1, 16'h0010, 2'd1, 1'b1, 16'h0020, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b0};
        vecs[8]  = '{1'b1, 16'h0010, 2'd1, 1'b1, 16'h0020, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b1};
        vecs[9]  = '{1'b1, 16'h0010, 2'd1, 1'b1, 16'h0020, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b0};
        // only r1 valid with rr_ptr=0: granted at once, rr_ptr stays 0
        vecs[10] = '{1'b0, 16'h0000, 2'd0, 1'b1, 16'h0030, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 1'b1};
        vecs[11] = '{1'b1, 16'h0010, 2'd1, 1'b1, 16'h0020, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0030, 1'b1};
        // drain without grant
        vecs[12] = '{1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};

        g1_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        reset = 1'b1;
        set_in(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_data",  a_out_data,  32'h0);
        chk("rst_out_id",    a_out_id,    1'b0);
        chk("rst_busy",      a_busy,      1'b0);
        chk("rst_b_out_valid", b_out_valid, 1'b0);

        // ---------------- vector table on instance a ----------------
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_in(vecs[i].r0v, vecs[i].r0i, vecs[i].r0e,
                   vecs[i].r1v, vecs[i].r1i, vecs[i].r1e, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_r0_ready", i), a_r0_ready, vecs[i].e_r0r);
            chk($sformatf("v%0d_r1_ready", i), a_r1_ready, vecs[i].e_r1r);
            chk($sformatf("v%0d_out_valid", i), a_out_valid, vecs[i].e_ov);
            chk($sformatf("v%0d_busy", i), a_busy, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_out_data", i), a_out_data, vecs[i].e_data);
                chk($sformatf("v%0d_out_id", i), a_out_id, vecs[i].e_id);
            end
        end

        // ---------------- backpressure (instance a, rr_ptr=1) ----------------
        @(negedge clk);
        set_in(1'b1, 16'h0100, 2'd1, 1'b1, 16'h0200, 2'd1, 1'b1);
        #1;
        chk("bp_first_r1_ready", a_r1_ready, 1'b1);
        chk("bp_first_r0_ready", a_r0_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            chk($sformatf("bp_stall%0d_out_valid", k), a_out_valid, 1'b1);
            chk($sformatf("bp_stall%0d_out_data", k), a_out_data, 32'h0000_0200);
            chk($sformatf("bp_stall%0d_out_id", k), a_out_id, 1'b1);
            chk($sformatf("bp_stall%0d_r0_ready", k), a_r0_ready, 1'b0);
            chk($sformatf("bp_stall%0d_r1_ready", k), a_r1_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_r0_ready", a_r0_ready, 1'b1);
        chk("bp_release_r1_ready", a_r1_ready, 1'b0);
        chk("bp_release_out_data", a_out_data, 32'h0000_0200);
        @(negedge clk);
        set_in(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
        #1;
        chk("bp_after_out_data",  a_out_data,  32'h0000_0100);
        chk("bp_after_out_id",    a_out_id,    1'b0);
        chk("bp_after_out_valid", a_out_valid, 1'b1);
        @(negedge clk);
        #1;
        chk("bp_drained_out_valid", a_out_valid, 1'b0);

        // ---------------- starvation bound (instance b) ----------------
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            set_in(1'b1, 16'h0010, 2'd1, 1'b1, 16'h0020, 2'd1, 1'b1);
            #1;
            chk($sformatf("starve_c%0d_r0_ready", c), b_r0_ready, !g1_exp[c]);
            chk($sformatf("starve_c%0d_r1_ready", c), b_r1_ready, g1_exp[c]);
            if (c == 5) chk("starve_forced_out_id", b_out_id, 1'b1);
        end
        @(negedge clk);
        set_in(1'b1, 16'h0010, 2'd1, 1'b0, 16'h0000, 2'd0, 1'b1);
        #1;
        chk("starve_resume_out_id", b_out_id, 1'b0);
        chk("pre_rst_a_r0_ready", a_r0_ready, 1'b1);

        // ---------------- reset while stalled (instance a, rr_ptr=1) ----------------
        @(negedge clk);
        set_in(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b0);
        #1;
        chk("pre_rst_out_valid", a_out_valid, 1'b1);
        chk("pre_rst_out_data",  a_out_data,  32'h0000_0010);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("stall_rst_out_valid", a_out_valid, 1'b0);
        chk("stall_rst_out_data",  a_out_data,  32'h0);
        chk("stall_rst_out_id",    a_out_id,    1'b0);
        chk("stall_rst_busy",      a_busy,      1'b0);
        chk("stall_rst_b_out_valid", b_out_valid, 1'b0);
        @(negedge clk);
        set_in(1'b1, 16'h0010, 2'd1, 1'b1, 16'h0020, 2'd1, 1'b1);
        #1;
        chk("rr_init_r0_ready", a_r0_ready, 1'b1);
        chk("rr_init_r1_ready", a_r1_ready, 1'b0);
        @(negedge clk);
        set_in(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
